// File: rtl/field_horner_eval_pkg.sv
// Shared types for the Horner-rule polynomial sequencer: field element width,
// operand payload carried to the external arithmetic units, and FSM states.
package field_horner_eval_pkg;

  localparam int unsigned F_NBITS = 32;

  typedef logic [F_NBITS-1:0] felem_t;

  typedef struct packed {
    felem_t a;
    felem_t b;
  } field_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } horner_state_t;

  // Width of the coefficient index; at least one bit even for a single coefficient.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/field_horner_eval_if.sv
// Request/completion bus between the sequencer (master) and one shared
// multiply unit plus one shared add unit (slave side).
interface field_horner_eval_if;
  import field_horner_eval_pkg::*;

  logic      mul_en;
  field_op_t mul_op;
  logic      mul_ready_pulse;
  felem_t    mul_c;

  logic      add_en;
  field_op_t add_op;
  logic      add_ready_pulse;
  felem_t    add_c;

  modport master (
    output mul_en, mul_op, add_en, add_op,
    input  mul_ready_pulse, mul_c, add_ready_pulse, add_c
  );

  modport slave (
    input  mul_en, mul_op, add_en, add_op,
    output mul_ready_pulse, mul_c, add_ready_pulse, add_c
  );

endinterface

// File: rtl/field_horner_eval.sv
// Evaluates sum(c[i] * x^i) by Horner's rule, sequencing an external multiply
// unit and an external add unit; all field arithmetic happens in those units.
module field_horner_eval
  import field_horner_eval_pkg::*;
#(
  parameter int unsigned NCOEFF = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  felem_t                    i_x,
  input  logic [NCOEFF*F_NBITS-1:0] i_coeffs,
  output logic                      o_busy,
  output logic                      o_done,
  output felem_t                    o_result,
  field_horner_eval_if.master       io_unit
);

  localparam int unsigned IDXW = idx_width(NCOEFF);
  localparam logic [IDXW-1:0] IDX_INIT = IDXW'((NCOEFF > 1) ? NCOEFF - 2 : 0);

  if (NCOEFF == 0) begin : g_illegal_ncoeff
    $error("field_horner_eval: NCOEFF must be at least 1");
  end

  horner_state_t   r_state, w_state_nxt;
  logic            r_start_dly;
  felem_t          r_x, w_x_nxt;
  felem_t          r_coef [NCOEFF];
  felem_t          r_acc, w_acc_nxt;
  felem_t          r_prod, w_prod_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic            w_coef_ld;
  logic            w_start_edge;

  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  felem_t          r_result, w_result_nxt;
  logic            r_mul_en, w_mul_en_nxt;
  field_op_t       r_mul_op, w_mul_op_nxt;
  logic            r_add_en, w_add_en_nxt;
  field_op_t       r_add_op, w_add_op_nxt;

  // start_dly resets high so a level held through reset is not an edge
  assign w_start_edge = i_start & ~r_start_dly;

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_acc_nxt    = r_acc;
    w_prod_nxt   = r_prod;
    w_idx_nxt    = r_idx;
    w_coef_ld    = 1'b0;
    w_result_nxt = r_result;
    w_mul_op_nxt = '0;
    w_add_op_nxt = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_coef_ld   = 1'b1;
          w_x_nxt     = i_x;
          w_acc_nxt   = i_coeffs[(NCOEFF-1)*F_NBITS +: F_NBITS];
          w_idx_nxt   = IDX_INIT;
          w_state_nxt = (NCOEFF == 1) ? ST_DONE : ST_MUL;
        end
      end
      ST_MUL: begin
        if (io_unit.mul_ready_pulse) begin
          w_prod_nxt  = io_unit.mul_c;
          w_state_nxt = ST_ADD;
        end
      end
      ST_ADD: begin
        if (io_unit.add_ready_pulse) begin
          w_acc_nxt = io_unit.add_c;
          if (r_idx == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx - IDXW'(1);
            w_state_nxt = ST_MUL;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs follow the next state so they are registered yet aligned with it
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_done_nxt   = (w_state_nxt == ST_DONE);
    w_mul_en_nxt = (w_state_nxt == ST_MUL);
    w_add_en_nxt = (w_state_nxt == ST_ADD);
    if (w_state_nxt == ST_DONE) w_result_nxt = w_acc_nxt;
    if (w_mul_en_nxt) begin
      w_mul_op_nxt.a = w_acc_nxt;
      w_mul_op_nxt.b = w_x_nxt;
    end
    if (w_add_en_nxt) begin
      w_add_op_nxt.a = w_prod_nxt;
      w_add_op_nxt.b = r_coef[w_idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_start_dly <= 1'b1;
      r_x         <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_mul_en    <= 1'b0;
      r_mul_op    <= '0;
      r_add_en    <= 1'b0;
      r_add_op    <= '0;
      for (int unsigned i = 0; i < NCOEFF; i++) r_coef[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_dly <= i_start;
      r_x         <= w_x_nxt;
      r_acc       <= w_acc_nxt;
      r_prod      <= w_prod_nxt;
      r_idx       <= w_idx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_result    <= w_result_nxt;
      r_mul_en    <= w_mul_en_nxt;
      r_mul_op    <= w_mul_op_nxt;
      r_add_en    <= w_add_en_nxt;
      r_add_op    <= w_add_op_nxt;
      if (w_coef_ld) begin
        for (int unsigned i = 0; i < NCOEFF; i++) r_coef[i] <= i_coeffs[i*F_NBITS +: F_NBITS];
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_result       = r_result;
  assign io_unit.mul_en = r_mul_en;
  assign io_unit.mul_op = r_mul_op;
  assign io_unit.add_en = r_add_en;
  assign io_unit.add_op = r_add_op;

endmodule

// File: tb/tb_field_horner_eval.sv
// Bench for field_horner_eval: behavioural mul/add units of latency 3 over
// GF(2^32-5), a vector table, and hand sequences for start/reset corner cases.
module tb_field_horner_eval;
  import field_horner_eval_pkg::*;

  localparam felem_t P     = 32'hFFFF_FFFB;
  localparam int     M_CYC = 3;
  localparam int     A_CYC = 3;
  localparam int     LAT4  = 1 + 3 * (M_CYC + A_CYC + 2);

  typedef struct { logic [127:0] coeffs; felem_t x; felem_t want; } vec_t;
  typedef struct { felem_t res; int cyc; } exp_t;
  typedef struct { felem_t res; int cyc; int busy_n; int mul_n; int add_n; } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NCOEFF = 4 instance
  logic           start4 = 1'b0;
  felem_t         x4 = '0;
  logic [127:0]   coeffs4 = '0;
  logic           busy4, done4;
  felem_t         result4;
  field_horner_eval_if if4 ();

  field_horner_eval #(.NCOEFF(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_x(x4), .i_coeffs(coeffs4),
    .o_busy(busy4), .o_done(done4), .o_result(result4), .io_unit(if4)
  );

  // NCOEFF = 1 instance; its units must never be requested
  logic           start1 = 1'b0;
  felem_t         x1 = '0;
  logic [31:0]    coeffs1 = '0;
  logic           busy1, done1;
  felem_t         result1;
  field_horner_eval_if if1 ();

  field_horner_eval #(.NCOEFF(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_x(x1), .i_coeffs(coeffs1),
    .o_busy(busy1), .o_done(done1), .o_result(result1), .io_unit(if1)
  );

  assign if1.mul_ready_pulse = 1'b0;
  assign if1.mul_c           = '0;
  assign if1.add_ready_pulse = 1'b0;
  assign if1.add_c           = '0;

  function automatic felem_t fmul(input felem_t a, input felem_t b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return felem_t'(p % {32'd0, P});
  endfunction

  function automatic felem_t fadd(input felem_t a, input felem_t b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return felem_t'(s % {1'b0, P});
  endfunction

  // Power-sum reference, independent of the Horner ordering
  function automatic felem_t ref_eval(input logic [127:0] c, input felem_t x);
    felem_t sum = '0;
    felem_t pw  = 32'd1;
    for (int i = 0; i < 4; i++) begin
      sum = fadd(sum, fmul(c[i*32 +: 32], pw));
      pw  = fmul(pw, x);
    end
    return sum;
  endfunction

  function automatic logic [127:0] pack4(input felem_t c0, input felem_t c1,
                                         input felem_t c2, input felem_t c3);
    return {c3, c2, c1, c0};
  endfunction

  // Multiply unit: edge-triggered en, ready pulse M_CYC cycles after the request
  logic   mul_rdy = 1'b0, mul_en_q = 1'b0;
  felem_t mul_res = '0, mul_pa = '0, mul_pb = '0;
  int     mul_cnt = 0, viol_mul = 0;
  always @(posedge clk) begin
    mul_rdy <= 1'b0;
    if (if4.mul_en && !mul_en_q) begin
      if (mul_cnt != 0) viol_mul <= viol_mul + 1;
      mul_cnt <= M_CYC - 1;
      mul_pa  <= if4.mul_op.a;
      mul_pb  <= if4.mul_op.b;
    end else if (mul_cnt != 0) begin
      mul_cnt <= mul_cnt - 1;
      if (mul_cnt == 1) begin
        mul_rdy <= 1'b1;
        mul_res <= fmul(mul_pa, mul_pb);
      end
    end
    mul_en_q <= if4.mul_en;
  end
  assign if4.mul_ready_pulse = mul_rdy;
  assign if4.mul_c           = mul_res;

  logic   add_rdy = 1'b0, add_en_q = 1'b0;
  felem_t add_res = '0, add_pa = '0, add_pb = '0;
  int     add_cnt = 0, viol_add = 0;
  always @(posedge clk) begin
    add_rdy <= 1'b0;
    if (if4.add_en && !add_en_q) begin
      if (add_cnt != 0) viol_add <= viol_add + 1;
      add_cnt <= A_CYC - 1;
      add_pa  <= if4.add_op.a;
      add_pb  <= if4.add_op.b;
    end else if (add_cnt != 0) begin
      add_cnt <= add_cnt - 1;
      if (add_cnt == 1) begin
        add_rdy <= 1'b1;
        add_res <= fadd(add_pa, add_pb);
      end
    end
    add_en_q <= if4.add_en;
  end
  assign if4.add_ready_pulse = add_rdy;
  assign if4.add_c           = add_res;

  // Output monitor: records every done with per-evaluation activity counts
  obs_t      obs[$];
  int        busy_cnt = 0, mul_edges = 0, add_edges = 0, viol_mon = 0, en1_hi = 0;
  logic      mul_en_seen = 1'b0, add_en_seen = 1'b0;
  field_op_t mul_op_seen = '0, add_op_seen = '0;
  always @(negedge clk) begin
    obs_t o;
    if (if1.mul_en || if1.add_en) en1_hi++;
    if (rst) begin
      busy_cnt  = 0;
      mul_edges = 0;
      add_edges = 0;
    end else begin
      if (busy4) busy_cnt++;
      if (if4.mul_en && !mul_en_seen) mul_edges++;
      if (if4.add_en && !add_en_seen) add_edges++;
      if (if4.mul_en && mul_en_seen && (if4.mul_op !== mul_op_seen)) viol_mon++;
      if (if4.add_en && add_en_seen && (if4.add_op !== add_op_seen)) viol_mon++;
      if (if4.mul_en && if4.add_en) viol_mon++;
      if (done4) begin
        o.res = result4; o.cyc = cyc; o.busy_n = busy_cnt;
        o.mul_n = mul_edges; o.add_n = add_edges;
        obs.push_back(o);
        busy_cnt  = 0;
        mul_edges = 0;
        add_edges = 0;
      end
    end
    mul_en_seen = if4.mul_en;
    add_en_seen = if4.add_en;
    mul_op_seen = if4.mul_op;
    add_op_seen = if4.add_op;
  end

  int   total = 0, bad = 0, obs_rd = 0;
  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  // Caller sits just after a rising edge; that cycle is t0
  task automatic start_eval(input vec_t v);
    exp_t e;
    coeffs4 = v.coeffs;
    x4      = v.x;
    start4  = 1'b1;
    e.res   = v.want;
    e.cyc   = cyc + LAT4;
    sb.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic expect_done(input int budget);
    exp_t e;
    obs_t o;
    int   n = 0;
    while (obs.size() <= obs_rd && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", (obs.size() > obs_rd) ? 1 : 0, 1);
    if (obs.size() > obs_rd && sb.size() != 0) begin
      e = sb.pop_front();
      o = obs[obs_rd];
      obs_rd++;
      check("result", o.res, e.res);
      check("done_cycle", o.cyc, e.cyc);
      check("busy_cycles", o.busy_n, LAT4);
      check("mul_en_rises", o.mul_n, 3);
      check("add_en_rises", o.add_n, 3);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    int   t0;

    vecs[0] = '{pack4(1, 2, 3, 4), 32'd2, 32'd49};
    vecs[1] = '{pack4(5, 0, 0, 0), 32'd7, 32'd5};
    vecs[2] = '{pack4(0, 0, 0, 1), 32'd3, 32'd27};
    vecs[3] = '{pack4(7, 1, 1, 1), 32'd0, 32'd7};
    vecs[4] = '{pack4(0, 1, 0, 0), P - 1, P - 1};
    vecs[5] = '{pack4(0, 0, 1, 0), P - 1, 32'd1};
    vecs[6] = '{pack4(1, 1, 1, 1), 32'd1, 32'd4};
    vecs[7] = '{pack4(0, 0, 0, 1), P - 1, P - 1};
    for (int i = 8; i < 10; i++) begin
      vecs[i].coeffs = pack4($urandom % P, $urandom % P, $urandom % P, $urandom % P);
      vecs[i].x      = $urandom % P;
      vecs[i].want   = ref_eval(vecs[i].coeffs, vecs[i].x);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_result", result4, 0);
    check("rst_mul_en", if4.mul_en, 0);
    check("rst_add_en", if4.add_en, 0);
    check("rst_mul_op", if4.mul_op, 0);
    check("rst_add_op", if4.add_op, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start_eval(vecs[i]);
      expect_done(LAT4 + 10);
    end

    // Second start edge mid-evaluation is dropped
    start_eval(vecs[0]);
    repeat (4) @(posedge clk); #1;
    coeffs4 = pack4(9, 9, 9, 9);
    x4      = 32'd3;
    start4  = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    expect_done(LAT4 + 10);

    // Start edge during the DONE cycle is dropped
    start_eval(vecs[2]);
    repeat (LAT4 - 1) @(posedge clk); #1;
    start4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("done_cycle_start_busy", busy4, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_cycle_start_busy2", busy4, 0);
    start4 = 1'b0;
    expect_done(5);

    // Back-to-back: restart in the first IDLE cycle after DONE
    start_eval(vecs[6]);
    repeat (LAT4) @(posedge clk); #1;
    start_eval(vecs[4]);
    expect_done(LAT4 + 10);
    expect_done(LAT4 + 10);

    // Start held high through reset does not start an evaluation
    rst    = 1'b1;
    start4 = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    @(negedge clk);
    check("held_start_busy", busy4, 0);
    check("held_start_no_done", obs.size() - obs_rd, 0);
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    start_eval(vecs[0]);
    expect_done(LAT4 + 10);

    // Reset during the second MUL: quiet outputs, no done, clean restart
    start_eval(vecs[1]);
    t0 = cyc - 1;
    while (cyc < t0 + 10) begin
      @(posedge clk); #1;
    end
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy4, 0);
    check("midrst_result", result4, 0);
    check("midrst_mul_en", if4.mul_en, 0);
    check("midrst_add_en", if4.add_en, 0);
    check("midrst_done", done4, 0);
    repeat (10) @(posedge clk); #1;
    check("midrst_no_done", obs.size() - obs_rd, 0);
    obs_rd = obs.size();
    v = vecs[8];
    start_eval(v);
    expect_done(LAT4 + 10);

    // NCOEFF = 1: done one cycle after the start edge, no unit requests
    coeffs1 = 32'd9;
    x1      = 32'd5;
    start1  = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    check("n1_done", done1, 1);
    check("n1_result", result1, 9);
    check("n1_busy", busy1, 1);
    @(negedge clk);
    check("n1_done_pulse", done1, 0);
    check("n1_busy_after", busy1, 0);
    check("n1_result_held", result1, 9);
    repeat (3) @(posedge clk); #1;

    check("operand_stability", viol_mon, 0);
    check("mul_request_overlap", viol_mul, 0);
    check("add_request_overlap", viol_add, 0);
    check("n1_unit_requests", en1_hi, 0);
    check("unconsumed_done", obs.size() - obs_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
